// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the 1RW SRAM controller and its synthesis wrappers.
package sram_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 11;
    localparam int DEF_RAM_DEPTH  = 2048;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int wmask_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/sram_1rw_array.sv
// Single-port storage with byte-masked write and registered read, no reset.
// Swap this module for a hard macro in the synthesis flow.
module sram_1rw_array #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 11,
    parameter int RAM_DEPTH   = 2048,
    parameter int WMASK_WIDTH = 4
) (
    input  logic                   clk0,
    input  logic                   en,
    input  logic                   we,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]  wdata,
    input  logic [WMASK_WIDTH-1:0] wmask,
    output logic [DATA_WIDTH-1:0]  rdata
);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    always_ff @(posedge clk0) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < WMASK_WIDTH; i++) begin
                    if (wmask[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/sram_1rw_wmask_ctrl.sv
// 1RW SRAM controller: init sweep, valid/ready request port and
// a one-entry read-response buffer with backpressure.
module sram_1rw_wmask_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int RAM_DEPTH   = DEF_RAM_DEPTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    parameter int WMASK_WIDTH = wmask_width(DATA_WIDTH)
) (
    input  logic                   clk0,
    input  logic                   rst0,
    input  logic                   clr0,
    output logic                   init_done,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    input  logic [WMASK_WIDTH-1:0] req_wmask,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   rsp_err
);

    // One extra bit so the terminal compare cannot wrap at full depth.
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RAM_DEPTH);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               run;
    logic               req_fire;
    logic               rd_fire;
    logic               addr_ok;

    logic                   arr_en;
    logic                   arr_we;
    logic [ADDR_WIDTH-1:0]  arr_addr;
    logic [DATA_WIDTH-1:0]  arr_wdata;
    logic [WMASK_WIDTH-1:0] arr_wmask;
    logic [DATA_WIDTH-1:0]  arr_rdata;

    assign run       = (state == ST_RUN);
    assign init_done = run;
    assign req_ready = run && !clr0 && (!rsp_valid || rsp_ready);
    assign req_fire  = req_valid && req_ready;
    assign rd_fire   = req_fire && !req_we;
    assign addr_ok   = ({1'b0, req_addr} < DEPTH_C);

    always_comb begin
        arr_en    = 1'b0;
        arr_we    = 1'b0;
        arr_addr  = req_addr;
        arr_wdata = req_wdata;
        arr_wmask = req_wmask;
        unique case (state)
            ST_INIT: begin
                arr_en    = !rst0;
                arr_we    = 1'b1;
                arr_addr  = cnt[ADDR_WIDTH-1:0];
                arr_wdata = INIT_VALUE;
                arr_wmask = '1;
            end
            ST_RUN: begin
                arr_en = req_fire && addr_ok;
                arr_we = req_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk0) begin
        if (rst0 || clr0) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else if (state == ST_INIT) begin
            if (cnt == CNT_LAST) begin
                state <= ST_RUN;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0 || clr0) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else if (rd_fire) begin
            rsp_valid <= 1'b1;
            rsp_err   <= !addr_ok;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // The array output register only moves on an accepted read,
    // so it holds while the response is stalled.
    assign rsp_rdata = (rsp_valid && !rsp_err) ? arr_rdata : '0;

    sram_1rw_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .RAM_DEPTH   (RAM_DEPTH),
        .WMASK_WIDTH (WMASK_WIDTH)
    ) u_array (
        .clk0  (clk0),
        .en    (arr_en),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .wmask (arr_wmask),
        .rdata (arr_rdata)
    );

endmodule
